// File: rtl/stage_1_arbiter_pkg.sv
// Shared definitions for the stage_1 arbiter: default widths, FSM encoding,
// requester identity, legacy opcode constants and the round-robin selector.
package stage_1_arbiter_pkg;

    localparam int FLT_DATA_WIDTH_DEF = 32;
    localparam int RES_WIDTH_DEF      = 66;
    localparam int TIMEOUT_DEF        = 255;
    localparam int CNT_WIDTH          = 8;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_GO    = 2'd1,
        OP_READ  = 2'd2
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_ISSUE   = 3'b001,
        S_WAIT    = 3'b010,
        S_RESPOND = 3'b011
    } arb_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    // On a tie the requester that was not served last wins.
    function automatic owner_e rr_pick(input logic req_a, input logic req_b, input owner_e last);
        owner_e pick;
        if (req_a && req_b) begin
            if (last == OWNER_A) pick = OWNER_B;
            else                 pick = OWNER_A;
        end else if (req_b) begin
            pick = OWNER_B;
        end else begin
            pick = OWNER_A;
        end
        return pick;
    endfunction

endpackage

// File: rtl/stage_1_arbiter.sv
// Two-requester round-robin front end for a single shared stage_1 datapath,
// with a completion timeout and a registered result/err hand-back.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no transaction; arbitrate between req_a / req_b
// S_ISSUE   | dp_start high for this one cycle, dp_ops already latched
// S_WAIT    | waiting for dp_done, timeout counter running
// S_RESPOND | done pulse to the owner, last-served pointer updated
module stage_1_arbiter
    import stage_1_arbiter_pkg::*;
#(
    parameter int FLT_DATA_WIDTH = FLT_DATA_WIDTH_DEF,
    parameter int RES_WIDTH      = RES_WIDTH_DEF,
    parameter int TIMEOUT        = TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        req_a,
    input  logic                        req_b,
    input  logic [3*FLT_DATA_WIDTH-1:0] ops_a,
    input  logic [3*FLT_DATA_WIDTH-1:0] ops_b,
    output logic                        done_a,
    output logic                        done_b,
    output logic [RES_WIDTH-1:0]        result,
    output logic                        err,
    output logic                        dp_start,
    output logic [3*FLT_DATA_WIDTH-1:0] dp_ops,
    input  logic                        dp_done,
    input  logic [RES_WIDTH-1:0]        dp_result
);

    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

    arb_state_e           state_q;
    arb_state_e           state_nxt;
    owner_e               owner_q;
    owner_e               last_q;
    owner_e               grant;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 any_req;
    logic                 timeout_hit;
    logic                 finish;

    assign any_req     = req_a | req_b;
    assign timeout_hit = (cnt_q == TO_LAST);
    // dp_done wins over a simultaneous timeout
    assign finish      = dp_done | timeout_hit;

    always_comb begin
        grant = rr_pick(req_a, req_b, last_q);
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:    if (any_req) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT:    if (finish) state_nxt = S_RESPOND;
            S_RESPOND: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (clk_en) begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWNER_A;
            last_q   <= OWNER_A;
            cnt_q    <= '0;
            dp_start <= 1'b0;
            dp_ops   <= '0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
        end else if (clk_en) begin
            dp_start <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q  <= grant;
                        dp_ops   <= (grant == OWNER_B) ? ops_b : ops_a;
                        dp_start <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= '0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (dp_done) begin
                        result <= dp_result;
                        err    <= 1'b0;
                    end else if (timeout_hit) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                    if (finish) begin
                        done_a <= (owner_q == OWNER_A);
                        done_b <= (owner_q == OWNER_B);
                    end
                end
                S_RESPOND: begin
                    last_q <= owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_1_arbiter.sv
// Scoreboard bench for stage_1_arbiter: a behavioural datapath/arbitration model
// predicts each grant and response; a separate monitor checks every done pulse.
module tb_stage_1_arbiter;

    localparam int OW = 96;
    localparam int RW = 66;

    typedef struct {
        bit            owner;
        logic [RW-1:0] res;
        bit            err;
        int            lat;
        int            start;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic          req_a, req_b;
    logic [OW-1:0] ops_a, ops_b;
    logic          done_a, done_b;
    logic [RW-1:0] result;
    logic          err;
    logic          dp_start;
    logic [OW-1:0] dp_ops;
    logic          dp_done;
    logic          dp_done_auto, dp_done_man;
    logic [RW-1:0] dp_result;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   starts = 0;
    int   done_cnt = 0;
    int   lat_cfg = 5;        // -1 random 1..20, 0 never respond
    int   stall_extra = 0;
    bit   fixed_res_en = 0;
    logic [RW-1:0] fixed_res = '0;
    exp_t exp_q[$];

    assign dp_done = dp_done_auto | dp_done_man;

    stage_1_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .req_a    (req_a),
        .req_b    (req_b),
        .ops_a    (ops_a),
        .ops_b    (ops_b),
        .done_a   (done_a),
        .done_b   (done_b),
        .result   (result),
        .err      (err),
        .dp_start (dp_start),
        .dp_ops   (dp_ops),
        .dp_done  (dp_done),
        .dp_result(dp_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, expv);
        end
    endtask

    // What the external stage_1 unit computes from its three operands.
    function automatic logic [RW-1:0] res_fn(input logic [OW-1:0] o);
        logic [RW-1:0] a, b, c;
        a = {o[31:0], 34'h0};
        b = RW'(o[63:32]) * RW'(3);
        c = RW'(o[95:64]) << 7;
        return (a ^ b ^ c) + RW'(7);
    endfunction

    function automatic logic [OW-1:0] rand_ops();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Datapath model + arbitration reference: predicts the grant, checks dp_ops,
    // pushes the expected response and answers dp_start after the chosen latency.
    initial begin
        bit            busy, snap_a, snap_b, own, m_last;
        logic [OW-1:0] snap_oa, snap_ob, exp_ops, filler;
        logic [RW-1:0] cur_res;
        int            rem, lat;
        exp_t          e;
        busy = 0; rem = 0; snap_a = 0; snap_b = 0; m_last = 0;
        snap_oa = '0; snap_ob = '0; cur_res = '0;
        dp_done_auto = 1'b0;
        dp_result = '0;
        forever begin
            @(negedge clk);
            dp_done_auto = 1'b0;
            filler = rand_ops();
            dp_result = filler[RW-1:0];
            if (busy) begin
                rem--;
                if (rem == 0) begin
                    dp_done_auto = 1'b1;
                    dp_result = cur_res;
                    busy = 0;
                end
            end
            if (rst) begin
                exp_q.delete();
                m_last = 0;
            end else if (dp_start) begin
                starts++;
                chk(snap_a || snap_b, "start_with_request", {snap_a, snap_b}, 2'b11);
                if (snap_a && snap_b) own = ~m_last;
                else                  own = snap_b;
                m_last = own;
                exp_ops = own ? snap_ob : snap_oa;
                chk(dp_ops == exp_ops, "dp_ops", dp_ops, exp_ops);
                lat = (lat_cfg < 0) ? $urandom_range(1, 20) : lat_cfg;
                cur_res = fixed_res_en ? fixed_res : res_fn(dp_ops);
                e.owner = own;
                e.start = cyc;
                if (lat == 0 || lat > 255) begin
                    e.res = '0;
                    e.err = 1;
                    e.lat = 256 + stall_extra;
                end else begin
                    e.res = fixed_res_en ? fixed_res : res_fn(exp_ops);
                    e.err = 0;
                    e.lat = lat + 1 + stall_extra;
                end
                exp_q.push_back(e);
                if (lat != 0) begin
                    busy = 1;
                    rem = lat;
                end
            end
            snap_a = req_a; snap_b = req_b;
            snap_oa = ops_a; snap_ob = ops_b;
        end
    end

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a || done_b) begin
                done_cnt++;
                chk(!(done_a && done_b), "single_done", {done_a, done_b}, 2'b01);
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_done", {done_a, done_b}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(done_b == e.owner, "done_owner", done_b, e.owner);
                    chk(result == e.res, "result", result, e.res);
                    chk(err == e.err, "err", err, e.err);
                    chk(cyc - e.start == e.lat, "latency", cyc - e.start, e.lat);
                end
            end
        end
    end

    task automatic wait_start(output bit got);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (dp_start) begin
                got = 1;
                break;
            end
        end
        chk(got, "dp_start_seen", got, 1);
    endtask

    task automatic wait_done(input bit who, input int maxc, output bit got);
        got = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk); #1;
            if (who ? done_b : done_a) begin
                got = 1;
                break;
            end
        end
        chk(got, "done_seen", got, 1);
    endtask

    // Requester: raise req with ops, hold until its own done, then drop.
    task automatic do_req(input bit who, input logic [OW-1:0] ops, input int gap);
        bit got;
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        if (who) begin ops_b = ops; req_b = 1'b1; end
        else     begin ops_a = ops; req_a = 1'b1; end
        wait_done(who, 600, got);
        if (who) req_b = 1'b0;
        else     req_a = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int s0, d0, n;
        bit got;
        bit exp_order[4];
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1; clk_en = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        ops_a = '0; ops_b = '0;
        dp_done_man = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk(done_a == 0 && done_b == 0, "rst_done", {done_a, done_b}, 0);
        chk(dp_start == 0, "rst_dp_start", dp_start, 0);
        chk(dp_ops == 0, "rst_dp_ops", dp_ops, 0);
        chk(result == 0 && err == 0, "rst_result_err", {err, result}, 0);
        chk(dut.state_q == 3'b000, "rst_state", dut.state_q, 0);
        rst = 1'b0;

        // single requester, fixed response 0x2A after 5 cycles
        fixed_res_en = 1; fixed_res = RW'(42); lat_cfg = 5;
        s0 = starts;
        do_req(0, {32'd3, 32'd2, 32'd1}, 1);
        repeat (4) @(posedge clk);
        #1;
        chk(starts - s0 == 1, "one_dp_start", starts - s0, 1);
        chk(result == RW'(42) && err == 0, "result_held", {err, result}, 42);
        fixed_res_en = 0;

        // simultaneous requests from reset, held high: B, A, B, A
        lat_cfg = -1;
        @(posedge clk); #1;
        rst = 1'b1;
        ops_a = rand_ops(); ops_b = rand_ops();
        req_a = 1'b1; req_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = starts; n = 0;
        for (int i = 0; i < 300 && n < 4; i++) begin
            @(posedge clk); #1;
            if (done_a || done_b) begin
                chk(done_b == exp_order[n], "rr_order", done_b, exp_order[n]);
                if (done_b) ops_b = rand_ops();
                else        ops_a = rand_ops();
                n++;
                if (n == 4) begin req_a = 1'b0; req_b = 1'b0; end
            end
        end
        chk(n == 4, "rr_four_grants", n, 4);
        req_a = 1'b0; req_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk(starts - s0 == 4, "rr_starts", starts - s0, 4);

        // randomized traffic from both requesters
        fork
            for (int i = 0; i < 15; i++) do_req(0, rand_ops(), $urandom_range(0, 6));
            for (int j = 0; j < 15; j++) do_req(1, rand_ops(), $urandom_range(0, 6));
        join

        // no response: timeout after the full WAIT window
        lat_cfg = 0;
        do_req(1, rand_ops(), 0);
        repeat (3) @(posedge clk);
        #1;
        chk(result == 0 && err == 1, "timeout_held", {err, result}, {1'b1, 66'h0});
        // response in the last WAIT cycle still completes
        lat_cfg = 255;
        do_req(0, rand_ops(), 1);
        // response one cycle too late is ignored
        lat_cfg = 256;
        do_req(1, rand_ops(), 1);

        // req dropped mid-transaction still gets its done
        lat_cfg = 8;
        @(posedge clk); #1;
        ops_b = rand_ops(); req_b = 1'b1;
        wait_start(got);
        req_b = 1'b0;
        wait_done(1, 40, got);

        // reset during WAIT, then a late dp_done
        lat_cfg = 20;
        @(posedge clk); #1;
        ops_a = rand_ops(); req_a = 1'b1;
        wait_start(got);
        repeat (5) @(posedge clk);
        #1;
        d0 = done_cnt; s0 = starts;
        rst = 1'b1; req_a = 1'b0;
        #1;
        chk(dut.state_q == 3'b000, "rst_async_state", dut.state_q, 0);
        chk(done_a == 0 && dp_start == 0 && dp_ops == 0, "rst_async_outs", {done_a, dp_start, dp_ops}, 0);
        chk(result == 0 && err == 0, "rst_async_result", {err, result}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk(done_cnt == d0, "no_done_after_rst", done_cnt - d0, 0);
        chk(starts == s0, "no_start_after_rst", starts - s0, 0);

        // clk_en low for 10 cycles in WAIT; dp_done seen meanwhile is dropped
        lat_cfg = 0; stall_extra = 10;
        @(posedge clk); #1;
        ops_a = rand_ops(); req_a = 1'b1;
        wait_start(got);
        repeat (6) @(posedge clk);
        #1;
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk(dut.cnt_q == 8'd5, "freeze_cnt", dut.cnt_q, 5);
            chk(dut.state_q == 3'b010, "freeze_state", dut.state_q, 3'b010);
            chk(done_a == 0 && dp_start == 0, "freeze_outs", {done_a, dp_start}, 0);
            dp_done_man = (i == 4);
            @(posedge clk); #1;
        end
        dp_done_man = 1'b0;
        clk_en = 1'b1;
        wait_done(0, 400, got);
        req_a = 1'b0;
        stall_extra = 0;

        repeat (5) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
